// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder; the encoder side uses the slave modport.
// err_count is present only when INST_ENCODER_ERRCNT_EN is defined.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] op_sel;
    logic        imm_sel;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [17:0] imm;
    logic [26:0] offset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err;
`ifdef INST_ENCODER_ERRCNT_EN
    logic [15:0] err_count;

    modport master (
        output in_valid, op_sel, imm_sel, rd, rs1, rs2, imm, offset, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err, err_count
    );
    modport slave (
        input  in_valid, op_sel, imm_sel, rd, rs1, rs2, imm, offset, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err, err_count
    );
`else
    modport master (
        output in_valid, op_sel, imm_sel, rd, rs1, rs2, imm, offset, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err
    );
    modport slave (
        input  in_valid, op_sel, imm_sel, rd, rs1, rs2, imm, offset, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err
    );
`endif
endinterface

// File: rtl/inst_encoder.sv
// One-hot instruction encoder feeding a DEPTH-entry output FIFO that tags each word with its byte address.
// Define INST_ENCODER_ERRCNT_EN to add a saturating 16-bit illegal-request counter (err_count).
module inst_encoder #(
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    inst_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [31:0]      addrCnt;
    logic [31:0]      instMem [DEPTH];
    logic [31:0]      addrMem [DEPTH];
    logic             errPulse;
    logic             inReady;
    logic             outValid;
    logic             pop;

    logic [4:0]       opIdx_p0;
    logic             opLegal_p0;
    logic             accept_p0;
    logic             push_p0;
    logic [31:0]      encWord_p0;

    // Index 13 is skipped in the opcode space, so ld and later shift up by one.
    function automatic logic [31:0] encode(
        input logic [4:0]  idx,
        input logic        immSel,
        input logic [3:0]  rd,
        input logic [3:0]  rs1,
        input logic [3:0]  rs2,
        input logic [17:0] imm,
        input logic [26:0] offset
    );
        logic [4:0] opc;
        logic [3:0] rdF;
        logic [3:0] rs1F;
        opc  = (idx < 5'd13) ? idx : idx + 5'd1;
        rdF  = (idx == 5'd5) ? 4'd0 : rd;
        rs1F = (idx == 5'd8 || idx == 5'd9) ? 4'd0 : rs1;
        if (idx == 5'd19)
            encode = {opc, 27'd0};
        else if (idx >= 5'd15)
            encode = {opc, offset};
        else
            encode = {opc, immSel, rdF, rs1F, immSel ? imm : {rs2, 14'd0}};
    endfunction

    // Stage p0: decode the request and form the word to enqueue
    always_comb begin
        opIdx_p0 = 5'd0;
        for (int i = 0; i < 20; i++) begin
            if (bus.op_sel[i]) opIdx_p0 = 5'(i);
        end
    end

    assign opLegal_p0 = (bus.op_sel != 20'd0) && ((bus.op_sel & (bus.op_sel - 20'd1)) == 20'd0);
    assign accept_p0  = bus.in_valid && inReady;
    assign push_p0    = accept_p0 && opLegal_p0;
    assign encWord_p0 = encode(opIdx_p0, bus.imm_sel, bus.rd, bus.rs1, bus.rs2, bus.imm, bus.offset);

    assign inReady  = !rst && (count < FULL_CNT);
    assign outValid = (count != '0);
    assign pop      = outValid && bus.out_ready;

    // FIFO control and address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            addrCnt  <= 32'd0;
            errPulse <= 1'b0;
        end else begin
            errPulse <= accept_p0 && !opLegal_p0;
            if (push_p0) begin
                wrPtr   <= wrPtr + PTR_W'(1);
                addrCnt <= addrCnt + 32'd4;
            end
            if (pop) rdPtr <= rdPtr + PTR_W'(1);
            case ({push_p0, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; outputs are masked by outValid instead.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            instMem[wrPtr] <= encWord_p0;
            addrMem[wrPtr] <= addrCnt;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_inst  = outValid ? instMem[rdPtr] : 32'd0;
    assign bus.out_addr  = outValid ? addrMem[rdPtr] : 32'd0;
    assign bus.err       = errPulse;

`ifdef INST_ENCODER_ERRCNT_EN
    logic [15:0] errCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            errCnt <= 16'd0;
        else if (accept_p0 && !opLegal_p0 && errCnt != 16'hFFFF)
            errCnt <= errCnt + 16'd1;
    end

    assign bus.err_count = errCnt;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed scoreboard bench for inst_encoder: the driver queues expected words, a negedge monitor checks them.
module tb_inst_encoder;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    inst_encoder_if bus ();

    inst_encoder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int errSeen = 0;
    int errExp = 0;
    int errCntExp = 0;
    logic [31:0] expAddr = 32'd0;
    logic [63:0] sbQ [$];

    bit          holdVld = 1'b0;
    logic [31:0] holdInst;
    logic [31:0] holdAddr;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a word is taken by the consumer
    always @(negedge clk) begin
        if (rst) begin
            holdVld = 1'b0;
        end else begin
            if (bus.err) errSeen++;
            if (holdVld)
                check("hold_stable", {1'b0, bus.out_valid, bus.out_inst, bus.out_addr[30:0]},
                      {1'b0, 1'b1, holdInst, holdAddr[30:0]});
            if (bus.out_valid && bus.out_ready) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got inst 0x%08h addr 0x%08h, expected none", bus.out_inst, bus.out_addr);
                end else begin
                    logic [63:0] e;
                    e = sbQ.pop_front();
                    check("out_inst", {33'd0, bus.out_inst}, {33'd0, e[63:32]});
                    check("out_addr", {33'd0, bus.out_addr}, {33'd0, e[31:0]});
                end
            end else if (!bus.out_valid) begin
                check("idle_zero", {1'b0, bus.out_inst, bus.out_addr}, 65'd0);
            end
            holdVld  = bus.out_valid && !bus.out_ready;
            holdInst = bus.out_inst;
            holdAddr = bus.out_addr;
        end
    end

    // Caller must be just after a rising edge; returns just after the transfer edge.
    task automatic sendReq(input logic [19:0] op, input logic iSel, input logic [3:0] d, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [17:0] im, input logic [26:0] off,
                           input logic [31:0] expInst, input bit legal);
        bit done;
        int waitCyc;
        bus.op_sel   = op;
        bus.imm_sel  = iSel;
        bus.rd       = d;
        bus.rs1      = s1;
        bus.rs2      = s2;
        bus.imm      = im;
        bus.offset   = off;
        bus.in_valid = 1'b1;
        done = 1'b0;
        waitCyc = 0;
        while (!done && waitCyc < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                if (legal) begin
                    sbQ.push_back({expInst, expAddr});
                    expAddr = expAddr + 32'd4;
                end else begin
                    errExp++;
                    errCntExp++;
                end
            end
            @(posedge clk);
            #1;
            waitCyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got in_ready 0 for 50 cycles, expected a transfer");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 65'(sbQ.size()), 65'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", {64'd0, bus.out_valid}, 65'd0);
        check("rst_in_ready",  {64'd0, bus.in_ready}, 65'd0);
        check("rst_outputs",   {1'b0, bus.out_inst, bus.out_addr}, 65'd0);
        check("rst_err",       {64'd0, bus.err}, 65'd0);
        sbQ.delete();
        expAddr = 32'd0;
        errCntExp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {64'd0, bus.in_ready}, 65'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_sel = 20'd0;
        bus.imm_sel = 1'b0;
        bus.rd = 4'd0;
        bus.rs1 = 4'd0;
        bus.rs2 = 4'd0;
        bus.imm = 18'd0;
        bus.offset = 27'd0;
        repeat (3) @(posedge clk);
        #1;
        check("init_out_valid", {64'd0, bus.out_valid}, 65'd0);
        check("init_in_ready",  {64'd0, bus.in_ready}, 65'd0);
        check("init_outputs",   {1'b0, bus.out_inst, bus.out_addr}, 65'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // add r3, r5, r7 into an empty FIFO: visible one cycle later at address 0
        sendReq(20'h00001, 1'b0, 4'd3, 4'd5, 4'd7, 18'd0, 27'd0, 32'h00D5C000, 1'b1);
        @(negedge clk);
        check("latency_valid", {64'd0, bus.out_valid}, 65'd1);
        check("latency_addr",  {33'd0, bus.out_addr}, 65'd0);
        @(posedge clk);
        #1;
        drain();

        // Mixed formats streamed back-to-back with out_ready high
        sendReq(20'h02000, 1'b1, 4'd1, 4'd2, 4'd0, 18'h00010, 27'd0, 32'h74480010, 1'b1);
        sendReq(20'h08000, 1'b0, 4'd0, 4'd0, 4'd0, 18'd0, 27'h0000100, 32'h80000100, 1'b1);
        sendReq(20'h00002, 1'b1, 4'd2, 4'd4, 4'd0, 18'h3FFFF, 27'd0, 32'h0C93FFFF, 1'b1);
        sendReq(20'h00020, 1'b0, 4'd9, 4'd3, 4'd4, 18'd0, 27'd0, 32'h280D0000, 1'b1);
        sendReq(20'h00100, 1'b0, 4'hF, 4'hA, 4'd1, 18'd0, 27'd0, 32'h43C04000, 1'b1);
        sendReq(20'h00200, 1'b1, 4'd6, 4'd5, 4'd0, 18'h0002A, 27'd0, 32'h4D80002A, 1'b1);
        sendReq(20'h01000, 1'b0, 4'd1, 4'd1, 4'd2, 18'd0, 27'd0, 32'h60448000, 1'b1);
        sendReq(20'h04000, 1'b1, 4'd0, 4'hF, 4'd0, 18'h20000, 27'd0, 32'h7C3E0000, 1'b1);
        sendReq(20'h10000, 1'b1, 4'd7, 4'd7, 4'd7, 18'h1FFFF, 27'h7FFFFFF, 32'h8FFFFFFF, 1'b1);
        sendReq(20'h20000, 1'b0, 4'd0, 4'd0, 4'd0, 18'd0, 27'h1234567, 32'h91234567, 1'b1);
        sendReq(20'h40000, 1'b0, 4'd0, 4'd0, 4'd0, 18'd0, 27'h0000004, 32'h98000004, 1'b1);
        sendReq(20'h80000, 1'b1, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 27'h7FFFFFF, 32'hA0000000, 1'b1);
        drain();

        // Back-pressure: fill the FIFO, confirm in_ready drops, then release in order
        doReset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++)
            sendReq(20'h00001, 1'b0, 4'(i), 4'd0, 4'd0, 18'd0, 27'd0, 32'h00400000 * i, 1'b1);
        @(negedge clk);
        check("full_in_ready", {64'd0, bus.in_ready}, 65'd0);
        check("full_out_valid", {64'd0, bus.out_valid}, 65'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        sendReq(20'h00001, 1'b0, 4'(DEPTH + 1), 4'd0, 4'd0, 18'd0, 27'd0, 32'h00400000 * (DEPTH + 1), 1'b1);
        drain();

        // Illegal requests: zero and multi-hot op_sel pulse err, enqueue nothing, keep address
        doReset();
        sendReq(20'h00000, 1'b0, 4'd1, 4'd1, 4'd1, 18'd0, 27'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("err_pulse_a", {64'd0, bus.err}, 65'd1);
        @(negedge clk);
        check("err_clear_a", {64'd0, bus.err}, 65'd0);
        @(posedge clk);
        #1;
        sendReq(20'h00003, 1'b0, 4'd1, 4'd1, 4'd1, 18'd0, 27'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("err_pulse_b", {64'd0, bus.err}, 65'd1);
        check("err_no_word", {64'd0, bus.out_valid}, 65'd0);
        @(negedge clk);
        check("err_clear_b", {64'd0, bus.err}, 65'd0);
        @(posedge clk);
        #1;
`ifdef INST_ENCODER_ERRCNT_EN
        check("err_count", {49'd0, bus.err_count}, 65'(errCntExp));
`endif
        sendReq(20'h00001, 1'b0, 4'd3, 4'd5, 4'd7, 18'd0, 27'd0, 32'h00D5C000, 1'b1);
        drain();

        // Reset with words queued discards them; ret then lands at address 0
        bus.out_ready = 1'b0;
        sendReq(20'h00001, 1'b0, 4'd1, 4'd0, 4'd0, 18'd0, 27'd0, 32'h00400000, 1'b1);
        sendReq(20'h00001, 1'b0, 4'd2, 4'd0, 4'd0, 18'd0, 27'd0, 32'h00800000, 1'b1);
        doReset();
        bus.out_ready = 1'b1;
        sendReq(20'h80000, 1'b0, 4'd0, 4'd0, 4'd0, 18'd0, 27'd0, 32'hA0000000, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        #1;
        check("err_total", 65'(errSeen), 65'(errExp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
